// File: rtl/apb_spi_fifo_bridge.sv
// APB slave that feeds a TX FIFO and drains an RX FIFO for an SPI master core.
// Full/empty accesses hold pready low for up to WAIT_LIMIT cycles, then complete with pslverr.

module apb_spi_fifo_bridge #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int WAIT_LIMIT    = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [ADDRESS_WIDTH-1:0]  paddr,
    input  logic                      pwrite,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    input  logic                      rx_valid,
    output logic                      rx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic            stall_en;
    logic            tx_flush_q;
    logic            rx_flush_q;

    logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]   tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]   tx_count, rx_count;

    logic [1:0]      reg_sel;
    logic            access, tx_full, tx_empty, rx_full, rx_empty;
    logic            wr_tx, rd_rx, hard_err, stall_cond, timed_out, done_ok;
    logic            tx_push, tx_pop, rx_push, rx_pop, ctrl_wr;
    logic [DATA_WIDTH-1:0] rd_word;
    logic            unused_bits;

    assign unused_bits = ^{pprot, paddr[ADDRESS_WIDTH-1:4], paddr[1:0]};

    assign reg_sel  = paddr[3:2];
    assign access   = psel & penable & (state != ST_IDLE);
    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);

    assign wr_tx      = pwrite & (reg_sel == 2'd0);
    assign rd_rx      = !pwrite & (reg_sel == 2'd1);
    assign hard_err   = pwrite & (((reg_sel == 2'd0) & !(&pstrb)) | (reg_sel == 2'd1) | (reg_sel == 2'd2));
    assign stall_cond = (wr_tx & (&pstrb) & tx_full) | (rd_rx & rx_empty);
    assign timed_out  = (wait_cnt == WW'(WAIT_LIMIT));

    assign pready  = access & (hard_err | !stall_cond | !stall_en | timed_out);
    assign pslverr = access & (hard_err | (stall_cond & (!stall_en | timed_out)));
    assign done_ok = pready & !pslverr;

    // SPI side ports: a word moves on each edge where valid & ready are both high;
    // valid never depends on ready and both come straight from the registered counts.
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign tx_data  = tx_mem[tx_rd_ptr];

    assign tx_push = done_ok & wr_tx;
    assign rx_pop  = done_ok & rd_rx;
    assign ctrl_wr = done_ok & pwrite & (reg_sel == 2'd3);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;

    // IDLE until a setup phase is seen; SETUP marks the first access cycle, ACCESS the stalled ones.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (psel && !penable) state <= ST_SETUP;
                end
                default: begin
                    if (!psel) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else if (!penable) begin
                        state    <= ST_SETUP;
                        wait_cnt <= '0;
                    end else if (pready) begin
                        state    <= ST_IDLE;
                        wait_cnt <= '0;
                    end else begin
                        state    <= ST_ACCESS;
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            stall_en   <= 1'b1;
            tx_flush_q <= 1'b0;
            rx_flush_q <= 1'b0;
        end else begin
            tx_flush_q <= ctrl_wr & pwdata[0];
            rx_flush_q <= ctrl_wr & pwdata[1];
            if (ctrl_wr) stall_en <= pwdata[2];
        end
    end

    // A pending flush wins over any push or pop on the same edge.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_flush_q) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush_q) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
        end
    end

    always_ff @(posedge pclk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= pwdata;
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            2'd1: rd_word = rx_mem[rx_rd_ptr];
            2'd2: begin
                rd_word[11:8] = 4'(rx_count);
                rd_word[7:4]  = 4'(tx_count);
                rd_word[3]    = rx_empty;
                rd_word[2]    = rx_full;
                rd_word[1]    = tx_empty;
                rd_word[0]    = tx_full;
            end
            2'd3: rd_word[2] = stall_en;
            default: rd_word = '0;
        endcase
    end

    assign prdata = (pready && !pwrite && !pslverr) ? rd_word : '0;

endmodule

// File: tb/tb_apb_spi_fifo_bridge.sv
// Self-checking bench for apb_spi_fifo_bridge: queue-based reference model compared every cycle,
// directed register-map scenarios with literal expectations, then randomized APB/SPI traffic.

module tb_apb_spi_fifo_bridge;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int WLIM  = 16;

    logic          pclk;
    logic          preset_n;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0] pwdata;
    logic [2:0]    pprot;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic [DW-1:0] tx_data;
    logic          tx_valid, tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ready;

    apb_spi_fifo_bridge #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .WAIT_LIMIT(WLIM)
    ) dut (
        .pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable),
        .paddr(paddr), .pwrite(pwrite), .pstrb(pstrb), .pwdata(pwdata), .pprot(pprot),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    // ---------------- clock ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;
    bit rand_spi = 1'b0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    bit m_stall_en = 1'b1;
    bit m_active   = 1'b0;
    int m_waits    = 0;
    bit m_txf      = 1'b0;
    bit m_rxf      = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected APB response for the current cycle, from the register-map rules.
    function automatic void model_eval(output bit e_ready, output bit e_err, output logic [DW-1:0] e_rdata);
        int sel;
        int txn;
        int rxn;
        bit stall;
        sel = int'(paddr[3:2]);
        txn = tx_q.size();
        rxn = rx_q.size();
        e_ready = 1'b0;
        e_err   = 1'b0;
        e_rdata = '0;
        case (sel)
            1: if (rxn > 0) e_rdata = rx_q[0];
            2: e_rdata = DW'(rxn * 256 + txn * 16 + (rxn == 0 ? 8 : 0) + (rxn == DEPTH ? 4 : 0)
                             + (txn == 0 ? 2 : 0) + (txn == DEPTH ? 1 : 0));
            3: e_rdata = m_stall_en ? DW'(4) : DW'(0);
            default: e_rdata = '0;
        endcase
        if (!(m_active && psel && penable)) return;
        if (pwrite && (sel == 1 || sel == 2 || (sel == 0 && pstrb != '1))) begin
            e_ready = 1'b1;
            e_err   = 1'b1;
            return;
        end
        stall = pwrite ? (sel == 0 && txn == DEPTH) : (sel == 1 && rxn == 0);
        if (!stall) begin
            e_ready = 1'b1;
        end else if (!m_stall_en || m_waits >= WLIM) begin
            e_ready = 1'b1;
            e_err   = 1'b1;
        end
    endfunction

    // Model state advance at each clock edge; asynchronous reset empties everything.
    always @(posedge pclk or negedge preset_n) begin : model_update
        bit r, e, ok, txpop, rxpush, txpush, rxpop, ctrl;
        logic [DW-1:0] d;
        int sel;
        if (!preset_n) begin
            tx_q.delete();
            rx_q.delete();
            m_stall_en = 1'b1;
            m_active   = 1'b0;
            m_waits    = 0;
            m_txf      = 1'b0;
            m_rxf      = 1'b0;
        end else begin
            model_eval(r, e, d);
            sel    = int'(paddr[3:2]);
            ok     = r && !e;
            txpop  = (tx_q.size() > 0) && tx_ready;
            rxpush = (rx_q.size() < DEPTH) && rx_valid;
            txpush = ok && pwrite && sel == 0;
            rxpop  = ok && !pwrite && sel == 1;
            ctrl   = ok && pwrite && sel == 3;
            if (m_txf) tx_q.delete();
            else begin
                if (txpop) void'(tx_q.pop_front());
                if (txpush) tx_q.push_back(pwdata);
            end
            if (m_rxf) rx_q.delete();
            else begin
                if (rxpop) void'(rx_q.pop_front());
                if (rxpush) rx_q.push_back(rx_data);
            end
            m_txf = ctrl && pwdata[0];
            m_rxf = ctrl && pwdata[1];
            if (ctrl) m_stall_en = pwdata[2];
            if (m_active && psel && penable) begin
                if (r) m_active = 1'b0;
                else m_waits++;
            end else if (psel && !penable) begin
                m_active = 1'b1;
                m_waits  = 0;
            end else begin
                m_active = 1'b0;
                m_waits  = 0;
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    always @(negedge pclk) begin : compare
        bit r, e;
        logic [DW-1:0] d;
        if (started) begin
            model_eval(r, e, d);
            check("pready", DW'(pready), DW'(r));
            check("pslverr", DW'(pslverr), DW'(e));
            if (r && !e && !pwrite) check("prdata", prdata, d);
            check("tx_valid", DW'(tx_valid), DW'(tx_q.size() != 0));
            if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
            check("rx_ready", DW'(rx_ready), DW'(rx_q.size() != DEPTH));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_step();
        if (rand_spi) begin
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = ($urandom_range(0, 1) == 0);
            rx_data  = $urandom;
        end
    endtask

    task automatic apb_xfer(input logic [1:0] sel, input bit wr, input logic [DW-1:0] wdata,
                            input logic [DW/8-1:0] strb, input int release_at, input bit abort,
                            output logic [DW-1:0] rdata, output bit err, output int waits);
        bit done;
        @(posedge pclk); #1;
        spi_step();
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = $urandom;
        paddr[3:2] = sel;
        pwrite  = wr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = 3'($urandom);
        @(posedge pclk); #1;
        spi_step();
        penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        rdata = '0;
        err   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge pclk);
            if (pready) begin
                done  = 1'b1;
                rdata = prdata;
                err   = pslverr;
            end else begin
                waits++;
                @(posedge pclk); #1;
                spi_step();
                if (waits == release_at) tx_ready = 1'b1;
                if (abort) begin
                    psel    = 1'b0;
                    penable = 1'b0;
                    break;
                end
            end
        end
        if (done) begin
            @(posedge pclk); #1;
            spi_step();
            psel    = 1'b0;
            penable = 1'b0;
        end else if (!abort) begin
            check("xfer_timeout", DW'(done), DW'(1));
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [DW-1:0] rd;
        bit er;
        int wt;
        logic [1:0] sel;
        bit wr;
        logic [DW-1:0] wd;
        logic [DW/8-1:0] st;
        bit ab;

        preset_n = 1'b0;
        psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pstrb = '0; pwdata = '0; pprot = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge pclk);
        started = 1'b1;
        @(negedge pclk);
        check("rst_pready", DW'(pready), DW'(0));
        check("rst_pslverr", DW'(pslverr), DW'(0));
        check("rst_prdata", prdata, '0);
        check("rst_tx_valid", DW'(tx_valid), DW'(0));
        check("rst_rx_ready", DW'(rx_ready), DW'(1));
        @(posedge pclk); #1;
        preset_n = 1'b1;

        apb_xfer(2'd3, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("ctrl_reset_val", rd, 32'h4);

        for (int i = 1; i <= DEPTH; i++) begin
            apb_xfer(2'd0, 1'b1, 32'hA5A5_0000 + DW'(i), '1, -1, 1'b0, rd, er, wt);
            check("tx_fill_waits", DW'(wt), DW'(0));
            check("tx_fill_err", DW'(er), DW'(0));
        end
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_tx_full", rd, 32'h89);
        check("tx_head_first", tx_data, 32'hA5A5_0001);

        apb_xfer(2'd0, 1'b1, 32'hA5A5_0009, '1, 2, 1'b0, rd, er, wt);
        check("stalled_push_waits", DW'(wt), DW'(3));
        check("stalled_push_err", DW'(er), DW'(0));
        tx_ready = 1'b0;
        check("tx_head_after_pops", tx_data, 32'hA5A5_0003);

        apb_xfer(2'd1, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("rx_timeout_waits", DW'(wt), DW'(WLIM));
        check("rx_timeout_err", DW'(er), DW'(1));
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_after_timeout", rd, 32'h78);

        apb_xfer(2'd3, 1'b1, 32'h0, '1, -1, 1'b0, rd, er, wt);
        apb_xfer(2'd1, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("nostall_waits", DW'(wt), DW'(0));
        check("nostall_err", DW'(er), DW'(1));
        apb_xfer(2'd3, 1'b1, 32'h4, '1, -1, 1'b0, rd, er, wt);

        @(posedge pclk); #1;
        rx_valid = 1'b1; rx_data = 32'h1234_5678;
        @(posedge pclk); #1;
        rx_data = 32'h9ABC_DEF0;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        apb_xfer(2'd1, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("rx_read_0", rd, 32'h1234_5678);
        check("rx_read_0_err", DW'(er), DW'(0));
        apb_xfer(2'd1, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("rx_read_1", rd, 32'h9ABC_DEF0);
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_rx_drained", rd, 32'h78);

        apb_xfer(2'd0, 1'b1, 32'hDEAD_BEEF, 4'h3, -1, 1'b0, rd, er, wt);
        check("partial_strb_err", DW'(er), DW'(1));
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_after_partial", rd, 32'h78);

        apb_xfer(2'd3, 1'b1, 32'h7, '1, -1, 1'b0, rd, er, wt);
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_after_flush", rd, 32'h0A);

        rand_spi = 1'b1;
        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom_range(0, 3));
            wr  = ($urandom_range(0, 1) == 0);
            if (sel == 2'd0) wr = ($urandom_range(0, 3) != 0);
            if (sel == 2'd1) wr = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 7) == 0) ? (DW/8)'($urandom) : '1;
            wd = $urandom;
            if (sel == 2'd3 && wr) begin
                wd[2]   = ($urandom_range(0, 3) != 0);
                wd[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
            end
            ab = ($urandom_range(0, 15) == 0);
            apb_xfer(sel, wr, wd, st, -1, ab, rd, er, wt);
        end
        rand_spi = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;

        apb_xfer(2'd3, 1'b1, 32'h7, '1, -1, 1'b0, rd, er, wt);
        for (int i = 0; i < DEPTH; i++)
            apb_xfer(2'd0, 1'b1, $urandom, '1, -1, 1'b0, rd, er, wt);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = '0; pwrite = 1'b1; pstrb = '1; pwdata = 32'h0BAD_0BAD;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b0;
        #1;
        check("rst_mid_pready", DW'(pready), DW'(0));
        check("rst_mid_tx_valid", DW'(tx_valid), DW'(0));
        check("rst_mid_rx_ready", DW'(rx_ready), DW'(1));
        psel = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        apb_xfer(2'd2, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("status_after_reset", rd, 32'h0A);
        apb_xfer(2'd3, 1'b0, '0, '0, -1, 1'b0, rd, er, wt);
        check("ctrl_after_reset", rd, 32'h4);

        repeat (2) @(posedge pclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2ms;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
